gate_enable_sequencer: RTL and testbench
========================================

Name: gate_enable_sequencer

Overview:
- Sequential enable generator that drives the A2 (enable) input of a downstream and2 gating cell; the cell's A1 carries the data or clock being gated.
- Runs a 4-phase REQ/ACK handshake with the requester.
- Applies a programmable turn-on delay, a minimum on-time and a turn-off settle delay, so the gated net never glitches or chatters.
- Sits in the same 5V0 7-track domain as the library cells it controls.

Parameters:
- CNT_W, 4: width of the internal delay counter.
- ON_DLY, 2: cycles from REQ sampled high to EN high; 0 is legal.
- MIN_ON, 3: minimum number of cycles EN stays high once asserted; 0 and 1 both give 1 cycle.
- OFF_DLY, 2: cycles ACK stays high after EN falls; 0 is legal.
- ON_DLY, MIN_ON and OFF_DLY must each be < 2^CNT_W. Elaboration fails otherwise.

Ports:
- CLK  input  1  Rising-edge clock; the only clock.
- RST  input  1  Synchronous, active-high reset.
- REQ  input  1  Enable request level from the requester (4-phase).
- KILL  input  1  Synchronous abort; forces the gate off.
- EN  output  1  Registered enable; drives A2 of the downstream and2.
- ACK  output  1  Handshake acknowledge.
- BUSY  output  1  High whenever the FSM is not in IDLE.
- ON_CNT  output  8  Count of activations; wraps modulo 256.
- VDD, VSS  inout  1  Present only when USE_POWER_PINS is defined; no functional effect.

Behaviour:
- All outputs are registered. Each item below describes the value visible after the named edge.
- Reset: RST sampled high puts the FSM in IDLE and forces EN=0, ACK=0, BUSY=0, ON_CNT=0 and the counter to 0. RST has priority over every other input.
- KILL: when sampled high (and RST low), the next state is IDLE with EN=0 and ACK=0, from any state. The FSM stays in IDLE while KILL=1 regardless of REQ. ON_CNT is not affected by KILL.
- States: IDLE, RAMP_UP, ACTIVE, RAMP_DN.
- IDLE (EN=0, ACK=0):
  - REQ=1 at edge E0 with ON_DLY=0: go to ACTIVE.
  - REQ=1 at edge E0 with ON_DLY>0: go to RAMP_UP with cnt=ON_DLY.
- RAMP_UP (EN=0, ACK=0):
  - REQ=0 at any edge: abort to IDLE. EN is never asserted and ON_CNT is unchanged.
  - Otherwise, if cnt==1: go to ACTIVE.
  - Otherwise: cnt decrements.
  - Net effect: EN and ACK go high after edge E0+ON_DLY.
- Entry into ACTIVE: rem=MIN_ON is loaded and ON_CNT increments (wrapping).
- ACTIVE (EN=1, ACK=1):
  - Exit when REQ=0 and rem<=1.
  - Otherwise rem decrements, saturating at 0.
  - Net effect: EN is high for at least max(MIN_ON,1) cycles.
  - If REQ drops and rises again before the exit condition is met, the FSM stays in ACTIVE.
- Exit from ACTIVE:
  - OFF_DLY=0: go directly to IDLE; EN and ACK fall on the same edge.
  - OFF_DLY>0: go to RAMP_DN with cnt=OFF_DLY.
- RAMP_DN (EN=0, ACK=1):
  - cnt decrements each edge.
  - At the edge where cnt==1, go to IDLE.
  - REQ is ignored in this state. A new request is honoured only from IDLE, on the first edge where REQ is sampled high.
- EN never rises and falls within one cycle.
- EN=1 implies ACK=1 on every cycle.

Test Plan:
1. Reset: RST=1 for 2 cycles with REQ=1 -> EN=ACK=BUSY=0 and ON_CNT=0 during reset. RST released, REQ held -> first edge after release is E0; EN=ACK=1 after E0+2.
2. Full handshake (ON_DLY=2, MIN_ON=3, OFF_DLY=2): REQ held for 10 cycles, then REQ sampled low at edge F -> EN falls after F, ACK falls after F+2, BUSY falls after F+2, ON_CNT=1.
3. Short request: REQ sampled high at E0 and low at E1 -> BUSY high only between E0 and E1; EN and ACK stay 0; ON_CNT stays 0.
4. Minimum on-time: EN rises at edge A0, and REQ is sampled low from A1 onward -> EN stays high through A3 and falls after A3 (exactly 3 cycles). A second run with MIN_ON=0 -> EN high for exactly 1 cycle.
5. KILL in ACTIVE: KILL=1 for 4 cycles with REQ=1 -> EN=ACK=0 after the KILL edge and the FSM stays in IDLE. KILL=0 -> EN high ON_DLY+1 edges later; ON_CNT increments by 1.
6. Re-request and wrap: REQ re-raised during RAMP_DN -> ignored until IDLE, then a fresh RAMP_UP starts. 256 back-to-back activations -> ON_CNT returns to 0.

Source files
------------

// File: rtl/gate_enable_sequencer.sv
// Enable sequencer for an and2 gating cell: 4-phase REQ/ACK handshake
// with turn-on delay, minimum on-time and turn-off settle delay.
module gate_enable_sequencer #(
  parameter int CNT_W   = 4,
  parameter int ON_DLY  = 2,
  parameter int MIN_ON  = 3,
  parameter int OFF_DLY = 2
) (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       KILL,
  output logic       EN,
  output logic       ACK,
  output logic       BUSY,
  output logic [7:0] ON_CNT
);

  if (ON_DLY  >= (1 << CNT_W) ||
      MIN_ON  >= (1 << CNT_W) ||
      OFF_DLY >= (1 << CNT_W)) begin : g_bad_param
    $error("delay parameter does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP_UP,
    S_ACTIVE,
    S_RAMP_DN
  } state_t;

  localparam logic [CNT_W-1:0] L_ON  = CNT_W'(ON_DLY);
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] L_OFF = CNT_W'(OFF_DLY);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en;
  logic             r_ack;
  logic             r_busy;
  logic [7:0]       r_on_cnt;
  logic             w_cnt_le1;

  assign w_cnt_le1 = (r_cnt <= L_ONE);

  // r_cnt is the ramp delay in RAMP_UP/RAMP_DN and the remaining
  // minimum on-time in ACTIVE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_en     <= 1'b0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_on_cnt <= 8'd0;
    end else if (KILL) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (REQ) begin
            r_busy <= 1'b1;
            if (ON_DLY == 0) begin
              r_state  <= S_ACTIVE;
              r_cnt    <= L_MIN;
              r_en     <= 1'b1;
              r_ack    <= 1'b1;
              r_on_cnt <= r_on_cnt + 8'd1;
            end else begin
              r_state <= S_RAMP_UP;
              r_cnt   <= L_ON;
            end
          end
        end
        S_RAMP_UP: begin
          if (!REQ) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_cnt_le1) begin
            r_state  <= S_ACTIVE;
            r_cnt    <= L_MIN;
            r_en     <= 1'b1;
            r_ack    <= 1'b1;
            r_on_cnt <= r_on_cnt + 8'd1;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_ACTIVE: begin
          if (!REQ && w_cnt_le1) begin
            r_en <= 1'b0;
            if (OFF_DLY == 0) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_ack   <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RAMP_DN;
              r_cnt   <= L_OFF;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_RAMP_DN: begin
          if (w_cnt_le1) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_en    <= 1'b0;
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign EN     = r_en;
  assign ACK    = r_ack;
  assign BUSY   = r_busy;
  assign ON_CNT = r_on_cnt;

endmodule

// File: tb/tb_gate_enable_sequencer.sv
// Bench for gate_enable_sequencer: cycle table on the default
// configuration plus corner sequences on a zero-delay instance.
module tb_gate_enable_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ = 1'b0;
  logic       KILL = 1'b0;
  logic       en0, ack0, busy0;
  logic [7:0] cnt0;
  logic       en1, ack1, busy1;
  logic [7:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  gate_enable_sequencer u0 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(CLK), .RST(RST), .REQ(REQ), .KILL(KILL),
    .EN(en0), .ACK(ack0), .BUSY(busy0), .ON_CNT(cnt0)
  );

  gate_enable_sequencer #(
    .CNT_W(4), .ON_DLY(0), .MIN_ON(0), .OFF_DLY(0)
  ) u1 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(CLK), .RST(RST), .REQ(REQ), .KILL(KILL),
    .EN(en1), .ACK(ack1), .BUSY(busy1), .ON_CNT(cnt1)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic       kill;
    logic       en;
    logic       ack;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, req, kill, en, ack, busy,
                     input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.kill = kill;
    v.en = en; v.ack = ack; v.busy = busy; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] base;
    int n;

    // reset with REQ high
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    // E0 and turn-on delay
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 1, 1, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 1, 1, 1, 1);
    // REQ low at F, settle delay
    add(0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    // short request aborts in RAMP_UP
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    // activate then KILL for 4 cycles
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 1, 1, 2);
    for (int i = 0; i < 4; i++) add(0, 1, 1, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 1, 2);
    add(0, 1, 0, 0, 0, 1, 2);
    add(0, 1, 0, 1, 1, 1, 3);
    // minimum on-time with REQ dropped right after A0
    add(0, 0, 0, 1, 1, 1, 3);
    add(0, 0, 0, 1, 1, 1, 3);
    add(0, 0, 0, 0, 1, 1, 3);
    // re-request during RAMP_DN is ignored until IDLE
    add(0, 1, 0, 0, 1, 1, 3);
    add(0, 1, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 0, 1, 3);
    add(0, 1, 0, 0, 0, 1, 3);
    add(0, 1, 0, 1, 1, 1, 4);
    // REQ glitch inside ACTIVE keeps EN high
    add(0, 0, 0, 1, 1, 1, 4);
    add(0, 1, 0, 1, 1, 1, 4);
    add(0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 4);

    foreach (vecs[i]) begin
      RST = vecs[i].rst;
      REQ = vecs[i].req;
      KILL = vecs[i].kill;
      tick();
      chk($sformatf("vec%0d", i),
          {21'd0, en0, ack0, busy0, cnt0},
          {21'd0, vecs[i].en, vecs[i].ack, vecs[i].busy, vecs[i].cnt});
      if (en0 && !ack0) chk("en_implies_ack", ack0, 1'b1);
    end

    // zero-delay instance: EN high for exactly one cycle
    base = cnt1;
    REQ = 1'b1;
    tick();
    chk("z_on", {en1, ack1, busy1}, 3'b111);
    chk("z_cnt", cnt1, base + 8'd1);
    chk("z_u0_ramp", {en0, busy0}, 2'b01);
    REQ = 1'b0;
    tick();
    chk("z_off", {en1, ack1, busy1}, 3'b000);
    tick();

    // 256 activations wrap ON_CNT
    base = cnt0;
    for (int i = 0; i < 256; i++) begin
      REQ = 1'b1;
      n = 0;
      while (!en0 && n < 20) begin tick(); n++; end
      chk("wrap_en_wait", en0, 1'b1);
      REQ = 1'b0;
      n = 0;
      while (busy0 && n < 20) begin tick(); n++; end
      chk("wrap_idle_wait", busy0, 1'b0);
    end
    chk("wrap_cnt", cnt0, base);

    // RST overrides an active gate and KILL
    REQ = 1'b1;
    n = 0;
    while (!en0 && n < 20) begin tick(); n++; end
    chk("pre_rst_en", en0, 1'b1);
    RST = 1'b1;
    KILL = 1'b1;
    tick();
    chk("rst_active", {en0, ack0, busy0, cnt0}, 11'd0);
    chk("rst_u1", {en1, ack1, busy1, cnt1}, 11'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
